// File: rtl/binenc_arb.sv
// binenc_arb: registered priority encoder / arbiter.
// Reduces an N-bit request vector, offered on a valid/ready handshake, to one
// granted channel. The grant (binary and one-hot) appears one cycle after accept.
// Arbitration is fixed-priority (highest index wins) or round-robin.
//
// Ports
//   clk         in   1  clock, rising edge
//   rst_n       in   1  asynchronous active-low reset
//   req         in   N  request vector, bit i = channel i requesting
//   req_valid   in   1  req is valid this cycle
//   req_ready   out  1  block accepts req this cycle (combinational)
//   gnt_valid   out  1  gnt_idx / gnt_onehot hold a grant
//   gnt_ready   in   1  consumer takes the grant this cycle
//   gnt_idx     out  W  binary index of the granted channel
//   gnt_onehot  out  N  one-hot grant, zero whenever gnt_valid is low

`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

module binenc_arb #(
    parameter  int unsigned N  = `DEFAULT_WIDTH,
    parameter  bit          RR = 1'b0,
    localparam int unsigned W  = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         req_valid,
    output logic         req_ready,
    output logic         gnt_valid,
    input  logic         gnt_ready,
    output logic [W-1:0] gnt_idx,
    output logic [N-1:0] gnt_onehot
);

    // Round-robin pointer: index of the last granted channel.
    logic [W-1:0] ptr;

    logic         accept;
    logic         pop;
    logic         req_any;

    logic [W-1:0] win_fixed;
    logic [W-1:0] win_rr;
    logic         hit_rr;
    logic [W-1:0] winner;
    int unsigned  pos;

    // Handshake: the single output register can take a new grant when empty
    // or when its current content leaves this cycle.
    assign req_ready = !gnt_valid || gnt_ready;
    assign accept    = req_valid && req_ready;
    assign pop       = gnt_valid && gnt_ready;
    assign req_any   = |req;

    // Fixed priority: ascending scan, so the highest set bit is written last.
    always_comb begin
        win_fixed = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[W'(i)]) begin
                win_fixed = W'(i);
            end
        end
    end

    // Round-robin: visit ptr-1, ptr-2, ... wrapping mod N, ending at ptr itself.
    // Positions are folded back into 0..N-1 so non-power-of-2 N never yields
    // an index >= N.
    always_comb begin
        win_rr = '0;
        hit_rr = 1'b0;
        pos    = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            pos = 32'(ptr) + N - k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!hit_rr && req[W'(pos)]) begin
                hit_rr = 1'b1;
                win_rr = W'(pos);
            end
        end
    end

    assign winner = RR ? win_rr : win_fixed;

    // Output register and pointer. req only reaches state through accept,
    // so an unqualified req never disturbs the held grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_valid  <= 1'b0;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
            ptr        <= '0;
        end else if (accept && req_any) begin
            gnt_valid  <= 1'b1;
            gnt_idx    <= winner;
            gnt_onehot <= N'(1) << winner;
            if (RR) begin
                ptr <= winner;
            end
        end else if (pop) begin
            // Popped with no replacement (no accept, or an all-zero request).
            gnt_valid  <= 1'b0;
            gnt_onehot <= '0;
        end
    end

endmodule

// File: tb/tb_binenc_arb.sv
// Bench for binenc_arb: three instances (fixed N=8, round-robin N=4, round-robin
// N=5) driven by directed scenarios and then random traffic, each checked every
// cycle against a behavioural model of the grant register and pointer.

module tb_binenc_arb;

    logic       clk;
    logic       rst_n;
    logic [2:0] rv;
    logic [2:0] gr;
    logic [2:0] rdy;
    logic [2:0] gv;

    logic [7:0] req0;
    logic [3:0] req1;
    logic [4:0] req2;
    logic [2:0] idx0;
    logic [1:0] idx1;
    logic [2:0] idx2;
    logic [7:0] oh0;
    logic [3:0] oh1;
    logic [4:0] oh2;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state per instance.
    int m_valid [3];
    int m_idx   [3];
    int m_ptr   [3];

    binenc_arb #(.N(8), .RR(1'b0)) u_fix8 (
        .clk(clk), .rst_n(rst_n), .req(req0), .req_valid(rv[0]), .req_ready(rdy[0]),
        .gnt_valid(gv[0]), .gnt_ready(gr[0]), .gnt_idx(idx0), .gnt_onehot(oh0));

    binenc_arb #(.N(4), .RR(1'b1)) u_rr4 (
        .clk(clk), .rst_n(rst_n), .req(req1), .req_valid(rv[1]), .req_ready(rdy[1]),
        .gnt_valid(gv[1]), .gnt_ready(gr[1]), .gnt_idx(idx1), .gnt_onehot(oh1));

    binenc_arb #(.N(5), .RR(1'b1)) u_rr5 (
        .clk(clk), .rst_n(rst_n), .req(req2), .req_valid(rv[2]), .req_ready(rdy[2]),
        .gnt_valid(gv[2]), .gnt_ready(gr[2]), .gnt_idx(idx2), .gnt_onehot(oh2));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int n_of(input int i);
        return (i == 0) ? 8 : ((i == 1) ? 4 : 5);
    endfunction

    function automatic bit rr_of(input int i);
        return i != 0;
    endfunction

    function automatic logic [31:0] req_cur(input int i);
        case (i)
            0:       return 32'(req0);
            1:       return 32'(req1);
            default: return 32'(req2);
        endcase
    endfunction

    function automatic logic [31:0] obs_idx(input int i);
        case (i)
            0:       return 32'(idx0);
            1:       return 32'(idx1);
            default: return 32'(idx2);
        endcase
    endfunction

    function automatic logic [31:0] obs_oh(input int i);
        case (i)
            0:       return 32'(oh0);
            1:       return 32'(oh1);
            default: return 32'(oh2);
        endcase
    endfunction

    // Winner from the arbitration rules; -1 when nothing is requested.
    function automatic int model_winner(input int i, input logic [31:0] r);
        int n;
        n = n_of(i);
        if (!rr_of(i)) begin
            for (int b = n - 1; b >= 0; b--) begin
                if (r[b]) return b;
            end
        end else begin
            for (int k = 1; k <= n; k++) begin
                int b;
                b = (m_ptr[i] - k + n) % n;
                if (r[b]) return b;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_valid[i] = 0;
            m_idx[i]   = 0;
            m_ptr[i]   = 0;
        end
    endtask

    task automatic drive(input int i, input bit v, input logic [31:0] r, input bit g);
        rv[i] = v;
        gr[i] = g;
        case (i)
            0:       req0 = r[7:0];
            1:       req1 = r[3:0];
            default: req2 = r[4:0];
        endcase
    endtask

    // One clock: check req_ready, advance the model, then check registered outputs.
    task automatic step();
        bit acc;
        bit pop;
        int w;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rdy%0d", i), 32'(rdy[i]), (m_valid[i] == 0 || gr[i]) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            acc = rv[i] && (m_valid[i] == 0 || gr[i]);
            pop = (m_valid[i] != 0) && gr[i];
            w   = model_winner(i, req_cur(i));
            if (acc && w >= 0) begin
                m_valid[i] = 1;
                m_idx[i]   = w;
                if (rr_of(i)) m_ptr[i] = w;
            end else if (pop) begin
                m_valid[i] = 0;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("gv%0d", i), 32'(gv[i]), 32'(m_valid[i]));
            check($sformatf("idx%0d", i), obs_idx(i), 32'(m_idx[i]));
            check($sformatf("oh%0d", i), obs_oh(i), (m_valid[i] != 0) ? (32'd1 << m_idx[i]) : 32'd0);
        end
    endtask

    int seq3 [6] = '{3, 2, 1, 0, 3, 2};
    int seq4 [3] = '{0, 2, 0};

    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 32'd0, 1'b1);
        model_reset();

        // Reset state.
        #2;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_gv%0d", i), 32'(gv[i]), 32'd0);
            check($sformatf("rst_idx%0d", i), obs_idx(i), 32'd0);
            check($sformatf("rst_oh%0d", i), obs_oh(i), 32'd0);
        end
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fixed priority: highest set bit of 0010_1100 is 5.
        drive(0, 1'b1, 32'h2C, 1'b1);
        step();
        check("t1_gv", 32'(gv[0]), 32'd1);
        check("t1_idx", obs_idx(0), 32'd5);
        check("t1_oh", obs_oh(0), 32'h20);

        // Backpressure: new req offered while the grant stalls.
        drive(0, 1'b1, 32'h81, 1'b0);
        repeat (5) begin
            step();
            check("t2_hold_idx", obs_idx(0), 32'd5);
            check("t2_hold_oh", obs_oh(0), 32'h20);
            check("t2_hold_rdy", 32'(rdy[0]), 32'd0);
        end
        drive(0, 1'b1, 32'h81, 1'b1);
        step();
        check("t2_new_idx", obs_idx(0), 32'd7);
        check("t2_new_oh", obs_oh(0), 32'h80);
        drive(0, 1'b0, 32'd0, 1'b1);
        step();
        check("t2_drain_gv", 32'(gv[0]), 32'd0);

        // Round-robin N=4, all requesting.
        drive(1, 1'b1, 32'hF, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step();
            check("t3_idx", obs_idx(1), 32'(seq3[k]));
        end

        // After a grant of 2, req=0101 alternates 0,2,0.
        drive(1, 1'b1, 32'h5, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("t4_idx", obs_idx(1), 32'(seq4[k]));
        end
        drive(1, 1'b1, 32'h4, 1'b1);
        step();
        check("t4_idx_a", obs_idx(1), 32'd2);
        step();
        check("t4_self", obs_idx(1), 32'd2);

        // Zero request while empty: nothing granted, pointer (2) kept.
        drive(1, 1'b0, 32'd0, 1'b1);
        step();
        check("t5_pop_gv", 32'(gv[1]), 32'd0);
        drive(1, 1'b1, 32'd0, 1'b1);
        step();
        check("t5_zero_gv", 32'(gv[1]), 32'd0);
        drive(1, 1'b1, 32'hF, 1'b1);
        step();
        check("t5_ptr_kept", obs_idx(1), 32'd1);
        drive(1, 1'b0, 32'd0, 1'b0);

        // N=5 wrap: grant 0, then 10001 wraps to 4.
        drive(2, 1'b1, 32'h01, 1'b1);
        step();
        check("t5_n5_first", obs_idx(2), 32'd0);
        drive(2, 1'b1, 32'h11, 1'b1);
        step();
        check("t5_n5_wrap", obs_idx(2), 32'd4);
        drive(2, 1'b0, 32'd0, 1'b1);

        // Asynchronous reset while the RR4 grant is held.
        check("t6_pre_gv", 32'(gv[1]), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_async_gv", 32'(gv[1]), 32'd0);
        check("t6_async_oh", obs_oh(1), 32'd0);
        check("t6_async_gv2", 32'(gv[2]), 32'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1, 1'b1, 32'hF, 1'b1);
        step();
        check("t6_ptr_reset", obs_idx(1), 32'd3);

        // Random traffic on all three instances.
        repeat (400) begin
            for (int i = 0; i < 3; i++) begin
                drive(i, ($urandom % 4) != 0,
                      (($urandom % 6) == 0) ? 32'd0 : 32'($urandom),
                      ($urandom % 10) < 7);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
